// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings and the FSM state type shared by axi_mem_slave.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_t;
endpackage

// File: rtl/axi_mem_slave_if.sv
// axi_mem_slave_if: AXI4 AW/W/B/AR/R signal bundle with master and slave views.
interface axi_mem_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
);
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;
    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, bid, input bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, rid, input rready
    );
    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, bid, output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
        input  rvalid, rdata, rresp, rlast, rid, output rready
    );
endinterface

// File: rtl/sram_1p_bytewe.sv
// sram_1p_bytewe: single-port SRAM with per-byte write enables and a 1-cycle registered read.
module sram_1p_bytewe #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_en,
    input  logic [DATA_W/8-1:0] i_we,
    input  logic [AW-1:0]       i_addr,
    input  logic [DATA_W-1:0]   i_wdata,
    output logic [DATA_W-1:0]   o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    // Output only updates when enabled, so a stalled reader sees stable data.
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int i = 0; i < DATA_W/8; i++)
                if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            o_rdata <= r_mem[i_addr];
        end
    end
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder serving bursts from a byte-writable SRAM,
// reads and writes serialized through one FSM with alternating-priority arbitration.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int                DATA_W = 64,
    parameter int                ID_W   = 4,
    parameter int                ADDR_W = 40,
    parameter logic [ADDR_W-1:0] BASE   = 40'h8000_0000,
    parameter int                DEPTH  = 4096
) (
    input logic             clock,
    input logic             reset,
    axi_mem_slave_if.slave  io_slave
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(8 * DEPTH);

    // Unsigned wrap makes addresses below BASE look huge, so one compare covers both bounds.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a - BASE) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    state_t              r_state;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_len, r_cnt;
    logic [2:0]          r_size;
    logic [1:0]          r_burst, r_rresp;
    logic                r_rlast, r_lg_wr, r_decerr, r_slverr;

    logic                w_grant_w, w_idle, w_aw_hs, w_ar_hs, w_r_hs, w_w_hs, w_w_last, w_w_in;
    logic [ADDR_W-1:0]   w_next, w_rd_addr, w_a_addr;
    logic [ID_W-1:0]     w_a_id;
    logic [7:0]          w_a_len;
    logic [2:0]          w_a_size;
    logic [1:0]          w_a_burst;
    logic                w_sram_en;
    logic [DATA_W/8-1:0] w_sram_we;
    logic [IDX_W-1:0]    w_sram_addr;
    logic [DATA_W-1:0]   w_q;

    // When both sides request, the side that did not win last time is granted.
    assign w_grant_w = io_slave.awvalid & (~io_slave.arvalid | ~r_lg_wr);
    assign w_idle    = reset & (r_state == IDLE);
    assign w_aw_hs   = w_idle & w_grant_w;
    assign w_ar_hs   = w_idle & io_slave.arvalid & ~w_grant_w;
    assign w_r_hs    = (r_state == RD) & io_slave.rready;
    assign w_w_hs    = (r_state == WR) & io_slave.wvalid;
    assign w_w_last  = r_cnt == r_len;
    assign w_w_in    = w_w_hs & in_range(r_addr);
    assign w_next    = r_burst == BURST_FIXED ? r_addr : r_addr + (ADDR_W'(1) << r_size);

    assign w_a_addr  = w_aw_hs ? io_slave.awaddr  : io_slave.araddr;
    assign w_a_id    = w_aw_hs ? io_slave.awid    : io_slave.arid;
    assign w_a_len   = w_aw_hs ? io_slave.awlen   : io_slave.arlen;
    assign w_a_size  = w_aw_hs ? io_slave.awsize  : io_slave.arsize;
    assign w_a_burst = w_aw_hs ? io_slave.awburst : io_slave.arburst;

    // The next beat's read is launched on the handshake that consumes the current one.
    assign w_rd_addr   = r_state == IDLE ? io_slave.araddr : w_next;
    assign w_sram_en   = w_ar_hs | (w_r_hs & ~r_rlast) | w_w_in;
    assign w_sram_we   = w_w_in ? io_slave.wstrb : '0;
    assign w_sram_addr = word_idx(r_state == WR ? r_addr : w_rd_addr);

    sram_1p_bytewe #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_sram (
        .i_clk   (clock),
        .i_en    (w_sram_en),
        .i_we    (w_sram_we),
        .i_addr  (w_sram_addr),
        .i_wdata (io_slave.wdata),
        .o_rdata (w_q)
    );

    assign io_slave.awready = w_aw_hs;
    assign io_slave.arready = w_ar_hs;
    assign io_slave.wready  = r_state == WR;
    assign io_slave.bvalid  = r_state == WR_RESP;
    assign io_slave.bid     = r_id;
    assign io_slave.bresp   = r_decerr ? RESP_DECERR : r_slverr ? RESP_SLVERR : RESP_OKAY;
    assign io_slave.rvalid  = r_state == RD;
    assign io_slave.rdata   = r_rresp == RESP_DECERR ? '0 : w_q;
    assign io_slave.rresp   = r_rresp;
    assign io_slave.rlast   = r_rlast;
    assign io_slave.rid     = r_id;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
            r_lg_wr  <= 1'b0;
            r_decerr <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_aw_hs | w_ar_hs) begin
                    r_state  <= w_aw_hs ? WR : RD;
                    r_id     <= w_a_id;
                    r_addr   <= w_a_addr;
                    r_len    <= w_a_len;
                    r_size   <= w_a_size;
                    r_burst  <= w_a_burst;
                    r_cnt    <= '0;
                    r_lg_wr  <= w_aw_hs;
                    r_decerr <= 1'b0;
                    r_slverr <= 1'b0;
                    r_rresp  <= (w_ar_hs & ~in_range(io_slave.araddr)) ? RESP_DECERR : RESP_OKAY;
                    r_rlast  <= w_ar_hs & (io_slave.arlen == 8'd0);
                end
                RD: if (w_r_hs) begin
                    if (r_rlast) begin
                        r_state <= IDLE;
                        r_rlast <= 1'b0;
                    end else begin
                        r_addr  <= w_next;
                        r_cnt   <= r_cnt + 8'd1;
                        r_rresp <= in_range(w_next) ? RESP_OKAY : RESP_DECERR;
                        r_rlast <= (r_cnt + 8'd1) == r_len;
                    end
                end
                WR: if (w_w_hs) begin
                    r_addr <= w_next;
                    r_cnt  <= r_cnt + 8'd1;
                    if (!in_range(r_addr)) r_decerr <= 1'b1;
                    if (io_slave.wlast != w_w_last) r_slverr <= 1'b1;
                    if (w_w_last) r_state <= WR_RESP;
                end
                WR_RESP: if (io_slave.bready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized and directed bursts checked against a word-array memory model.
module tb_axi_mem_slave;
    localparam int          DEPTH = 4096;
    localparam logic [39:0] BASE  = 40'h8000_0000;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    axi_mem_slave_if #(.ID_W(4), .ADDR_W(40), .DATA_W(64)) bus ();

    axi_mem_slave #(.DATA_W(64), .ID_W(4), .ADDR_W(40), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .io_slave (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mdl [DEPTH];
    logic [1:0]  exp_bresp;
    logic [63:0] last_rdata;

    function automatic logic [39:0] beat_addr(input logic [39:0] a, input int b, input logic [2:0] sz, input logic [1:0] bu);
        return (bu == 2'd0) ? a : a + 40'(b * (1 << sz));
    endfunction

    function automatic bit inr(input logic [39:0] a);
        return a >= BASE && a < BASE + 40'(8 * DEPTH);
    endfunction

    function automatic int widx(input logic [39:0] a);
        return int'((a - BASE) / 40'd8);
    endfunction

    task automatic aw_hs(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id);
        int n;
        n = 0;
        @(negedge clock);
        bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bu; bus.awid = id; bus.awvalid = 1'b1;
        #1;
        while (!bus.awready && n < 50) begin @(negedge clock); #1; n++; end
        checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL aw_grant: awready=%b want 1 within 50 cycles", bus.awready); end
        @(negedge clock);
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id);
        int n;
        n = 0;
        @(negedge clock);
        bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bu; bus.arid = id; bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 50) begin @(negedge clock); #1; n++; end
        checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL ar_grant: arready=%b want 1 within 50 cycles", bus.arready); end
        @(negedge clock);
        bus.arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu,
                          input int wl_pos, input logic [63:0] d0, input logic [7:0] strb, input bit rnd);
        bit dec, slv;
        logic [39:0] ba;
        logic [63:0] d;
        dec = 0; slv = 0;
        for (int b = 0; b <= int'(len); b++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(negedge clock); end
            ba = beat_addr(a, b, sz, bu);
            d = (b == 0 && !rnd) ? d0 : {$urandom, $urandom};
            bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = strb; bus.wlast = (b == wl_pos);
            #1;
            checks++; if (bus.wready !== 1'b1) begin errors++; $display("FAIL w_ready beat %0d: got %b want 1", b, bus.wready); end
            if (inr(ba)) begin
                for (int i = 0; i < 8; i++) if (strb[i]) mdl[widx(ba)][8*i +: 8] = d[8*i +: 8];
            end else dec = 1;
            if ((b == wl_pos) != (b == int'(len))) slv = 1;
            @(negedge clock);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        exp_bresp = dec ? 2'd3 : slv ? 2'd2 : 2'd0;
    endtask

    task automatic get_b(input logic [3:0] id, input int delay);
        #1;
        checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL b_timing: bvalid=%b want 1 one cycle after last W", bus.bvalid); end
        repeat (delay) @(negedge clock);
        #1;
        checks++; if ({bus.bvalid, bus.bid, bus.bresp} !== {1'b1, id, exp_bresp})
            begin errors++; $display("FAIL b_resp: valid/id/resp=%b/%h/%0d want 1/%h/%0d", bus.bvalid, bus.bid, bus.bresp, id, exp_bresp); end
        bus.bready = 1'b1;
        @(negedge clock);
        bus.bready = 1'b0;
        #1;
        checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL b_drop: bvalid=%b want 0", bus.bvalid); end
    endtask

    task automatic get_r(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id, input bit stall);
        logic [39:0] ba;
        logic [63:0] ed;
        logic [1:0]  er;
        int          reps;
        for (int b = 0; b <= int'(len); b++) begin
            ba = beat_addr(a, b, sz, bu);
            ed = inr(ba) ? mdl[widx(ba)] : 64'd0;
            er = inr(ba) ? 2'd0 : 2'd3;
            reps = stall ? 2 : 1;
            for (int k = 0; k < reps; k++) begin
                bus.rready = (k == reps - 1);
                #1;
                checks++; if ({bus.rvalid, bus.rlast, bus.rresp, bus.rid} !== {1'b1, b == int'(len), er, id})
                    begin errors++; $display("FAIL r_ctrl beat %0d: valid/last/resp/id=%b/%b/%0d/%h want 1/%b/%0d/%h", b, bus.rvalid, bus.rlast, bus.rresp, bus.rid, b == int'(len), er, id); end
                checks++; if (bus.rdata !== ed) begin errors++; $display("FAIL r_data beat %0d: got %h want %h", b, bus.rdata, ed); end
                last_rdata = bus.rdata;
                @(negedge clock);
            end
        end
        bus.rready = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL r_end: rvalid=%b want 0 after last beat", bus.rvalid); end
    endtask

    task automatic do_write(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu,
                            input logic [3:0] id, input int wl_pos, input logic [63:0] d0, input logic [7:0] strb, input bit rnd);
        aw_hs(a, len, sz, bu, id);
        send_w(a, len, sz, bu, wl_pos, d0, strb, rnd);
        get_b(id, rnd ? $urandom_range(0, 2) : 0);
    endtask

    task automatic do_read(input logic [39:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] id, input bit stall);
        ar_hs(a, len, sz, bu, id);
        get_r(a, len, sz, bu, id, stall);
    endtask

    task automatic test_reset;
        @(negedge clock);
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        #1;
        checks++; if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp, bus.rid, bus.bid} !== 18'd0)
            begin errors++; $display("FAIL reset_outputs: aw/ar/w/b/r ready-valid=%b%b%b%b%b rlast=%b bresp=%0d rresp=%0d rid=%h bid=%h want all 0",
                bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast, bus.bresp, bus.rresp, bus.rid, bus.bid); end
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_contention;
        @(negedge clock);
        bus.awaddr = BASE + 40'h100; bus.awlen = 0; bus.awsize = 3; bus.awburst = 1; bus.awid = 4'h1; bus.awvalid = 1'b1;
        bus.araddr = BASE + 40'h100; bus.arlen = 0; bus.arsize = 3; bus.arburst = 1; bus.arid = 4'h2; bus.arvalid = 1'b1;
        #1;
        checks++; if ({bus.awready, bus.arready} !== 2'b10) begin errors++; $display("FAIL contend_first: aw/ar ready=%b%b want 10", bus.awready, bus.arready); end
        @(negedge clock);
        bus.awvalid = 1'b0;
        #1;
        checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL ar_blocked: arready=%b want 0 during write", bus.arready); end
        send_w(BASE + 40'h100, 0, 3, 1, 0, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 0);
        get_b(4'h1, 0);
        bus.awvalid = 1'b1;
        #1;
        checks++; if ({bus.awready, bus.arready} !== 2'b01) begin errors++; $display("FAIL contend_second: aw/ar ready=%b%b want 01 at B+1", bus.awready, bus.arready); end
        @(negedge clock);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        get_r(BASE + 40'h100, 0, 3, 1, 4'h2, 0);
        checks++; if (last_rdata !== 64'hCAFE_F00D_DEAD_BEEF) begin errors++; $display("FAIL turnaround_data: got %h want cafef00ddeadbeef", last_rdata); end
    endtask

    task automatic test_single;
        do_write(40'h8000_0008, 0, 3, 1, 4'h3, 0, 64'h1122_3344_5566_7788, 8'hFF, 0);
        do_read(40'h8000_0008, 0, 3, 1, 4'h5, 0);
        checks++; if (last_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL single_data: got %h want 1122334455667788", last_rdata); end
    endtask

    task automatic test_incr_stall;
        do_write(BASE, 3, 3, 1, 4'h6, 3, 64'd0, 8'hFF, 1);
        do_read(BASE, 3, 3, 1, 4'h7, 1);
    endtask

    task automatic test_partial_strobe;
        do_write(BASE + 40'h10, 0, 3, 1, 4'h8, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        do_write(BASE + 40'h10, 0, 3, 1, 4'h8, 0, 64'd0, 8'h0F, 0);
        do_read(BASE + 40'h10, 0, 3, 1, 4'h9, 0);
        checks++; if (last_rdata !== 64'hFFFF_FFFF_0000_0000) begin errors++; $display("FAIL partial_strobe: got %h want ffffffff00000000", last_rdata); end
    endtask

    task automatic test_boundary;
        do_write(BASE + 40'(8 * DEPTH - 8), 0, 3, 1, 4'hA, 0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
        do_read(BASE + 40'(8 * DEPTH - 8), 1, 3, 1, 4'hB, 0);
        checks++; if (last_rdata !== 64'd0) begin errors++; $display("FAIL oor_rdata: got %h want 0", last_rdata); end
        do_write(BASE + 40'(8 * DEPTH - 8), 1, 3, 1, 4'hC, 1, 64'h5555_AAAA_5555_AAAA, 8'hFF, 0);
        do_read(BASE - 40'd8, 1, 3, 1, 4'hD, 0);
    endtask

    task automatic test_wlast_err;
        do_write(BASE + 40'h20, 1, 3, 1, 4'h2, 0, 64'h1, 8'hFF, 0);
        do_write(BASE + 40'h30, 2, 3, 0, 4'h4, -1, 64'h2, 8'hFF, 0);
        do_write(BASE - 40'd8, 0, 3, 1, 4'hE, -1, 64'h3, 8'hFF, 0);
        do_read(BASE + 40'h20, 1, 3, 1, 4'h1, 0);
    endtask

    task automatic test_reset_mid;
        do_write(BASE + 40'h40, 7, 3, 1, 4'h3, 7, 64'd0, 8'hFF, 1);
        ar_hs(BASE + 40'h40, 7, 3, 1, 4'h4);
        bus.rready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if ({bus.rvalid, bus.rlast, bus.arready, bus.awready} !== 4'b0) begin errors++; $display("FAIL reset_mid_read: rvalid/rlast/arready/awready=%b%b%b%b want 0000", bus.rvalid, bus.rlast, bus.arready, bus.awready); end
        @(negedge clock);
        bus.rready = 1'b0; reset = 1'b1;
        aw_hs(BASE + 40'h200, 3, 3, 1, 4'h5);
        reset = 1'b0;
        #1;
        checks++; if ({bus.wready, bus.bvalid} !== 2'b0) begin errors++; $display("FAIL reset_mid_write: wready/bvalid=%b%b want 00", bus.wready, bus.bvalid); end
        @(negedge clock);
        reset = 1'b1;
        do_read(BASE + 40'h40, 7, 3, 1, 4'h6, 0);
    endtask

    task automatic test_random;
        int s;
        logic [39:0] a;
        logic [7:0]  len;
        logic [2:0]  sz;
        logic [1:0]  bu;
        logic [3:0]  id;
        do_write(BASE, 63, 3, 1, 4'h0, 63, 64'd0, 8'hFF, 1);
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 59)) - 4;
            a = BASE + 40'(s * 8);
            len = 8'($urandom_range(0, 7));
            sz = 3'($urandom_range(2, 3));
            bu = 2'($urandom_range(0, 2));
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_write(a, len, sz, bu, id, ($urandom_range(0, 9) == 0) ? -1 : int'(len), 64'd0, 8'($urandom), 1);
            else
                do_read(a, len, sz, bu, id, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.awvalid = 0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 0;
        #2 reset = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_incr_stall();
        test_partial_strobe();
        test_boundary();
        test_wlast_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 responder that serves a CPU-side AXI4 master from an on-chip, byte-writable single-port SRAM. It is the far end of the 64-bit `io_master_*` bus driven by `riscv_cpu_top`, and is used as boot/scratch memory in simulation and FPGA builds. Reads and writes are serialized through one FSM with alternating-priority arbitration.

## Interface

**Parameters**
- `DATA_W`, 64: data width; only 64 is supported.
- `ID_W`, 4: AXI ID width.
- `ADDR_W`, 40: AXI address width.
- `BASE`, 40'h80000000: byte address of word 0.
- `DEPTH`, 4096: number of 64-bit words; must be a power of two.

**Ports**
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low reset.
- `io_slave_awvalid`/`awready` in/out 1; `awaddr` in `ADDR_W`; `awid` in `ID_W`; `awlen` in 8; `awsize` in 3; `awburst` in 2.
- `io_slave_wvalid`/`wready` in/out 1; `wdata` in 64; `wstrb` in 8; `wlast` in 1.
- `io_slave_bvalid` out 1; `bready` in 1; `bresp` out 2; `bid` out `ID_W`.
- `io_slave_arvalid`/`arready` in/out 1; `araddr` in `ADDR_W`; `arid` in `ID_W`; `arlen` in 8; `arsize` in 3; `arburst` in 2.
- `io_slave_rvalid` out 1; `rready` in 1; `rdata` out 64; `rresp` out 2; `rlast` out 1; `rid` out `ID_W`.
- prot/cache/lock/qos/user are not ported. The top level leaves them unconnected.

## Operation

**FSM states:** IDLE, RD, WR, WR_RESP.

**IDLE**
- `awready` = grant_w & `awvalid`; `arready` = grant_r & `arvalid`.
- If only one request is valid, it is granted.
- If both are valid, the side opposite to `last_grant` is granted. `last_grant` resets to "read", so the first contended grant goes to the write.
- On a handshake the block latches id, addr, len, size and burst, clears the beat counter, and moves to RD or WR.

**Address step (per beat)**
- FIXED: address unchanged.
- INCR: address += 1<<size.
- WRAP: treated as INCR.
- Address arithmetic is modulo 2^`ADDR_W`.
- Word index = (addr − `BASE`)[log2(DEPTH)+2:3].
- A beat is in range iff `BASE` ≤ addr < `BASE`+8·`DEPTH`.

**RD**
- The SRAM read of beat 0 is issued on the AR handshake cycle.
- `rvalid` holds until `rready`. On each R handshake, the next beat's read is issued the same cycle.
- SRAM enable is low while stalled, so `rdata` stays stable.
- `rresp` is set per beat: OKAY in range; DECERR out of range, with `rdata` = 0.
- `rlast` is asserted on beat `arlen`. The R handshake on that beat returns the FSM to IDLE.

**WR**
- `wready` = 1.
- Each W handshake writes `wdata` under `wstrb` if the beat is in range. Out-of-range beats are dropped and set a sticky DECERR flag.
- If `wlast` disagrees with beat count == `awlen`, a sticky SLVERR flag is set.
- The beat count is authoritative: the burst ends after `awlen`+1 beats.

**WR_RESP**
- `bvalid` = 1 with `bid` set to the latched AW id.
- `bresp` priority: DECERR > SLVERR > OKAY.
- The B handshake returns the FSM to IDLE.

**Reset**
- All valid and ready outputs = 0; `bresp`/`rresp` = 0; `rlast` = 0; `rid`/`bid` = 0; state = IDLE.
- A reset asserted mid-burst abandons the burst. SRAM contents are not cleared.

## Timing

- AR handshake at cycle T → first `rvalid` at T+1. With `rready` held high, beats follow at 1 beat/cycle.
- AW handshake at T → `wready` from T+1. The last W beat at cycle L → `bvalid` at L+1.
- Write-then-read turnaround: B handshake at cycle B → earliest `arready` at B+1. The read returns the written data, with no hazard.
- `awready` and `arready` are never high in the same cycle. No ready output depends combinationally on the same channel's valid except in IDLE.

## Structure

- Package `axi_pkg` holds:
  - burst encodings (FIXED=0, INCR=1, WRAP=2);
  - resp codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - the FSM state enum.
- Sub-module `sram_1p_bytewe` provides `DEPTH`×64 storage with 8 byte enables and a 1-cycle registered read. Its output holds when not enabled.

## Test plan

1. Write a single beat (addr 0x8000_0008, data 0x1122334455667788, strb 0xFF), then read it back. Expected: `bresp`=OKAY; `rdata`=0x1122334455667788 with `rlast`=1 at AR+1.
2. INCR read, `arlen`=3, from 0x8000_0000 with `rready` toggled 1/0. Expected: 4 beats, in order, each held stable while stalled; `rlast` only on the 4th beat.
3. Partial strobe write `wstrb`=0x0F over 0xFFFF…FF with data 0. Expected: readback = 0xFFFFFFFF00000000.
4. AW and AR valid in the same IDLE cycle straight out of reset. Expected: write granted first; next contention grants the read.
5. Read at `BASE`+8·`DEPTH`−8 with `arlen`=1. Expected: beat 0 OKAY; beat 1 DECERR with `rdata`=0.
6. Write `awlen`=1 with `wlast` set on beat 0. Expected: two beats consumed; `bresp`=SLVERR. Reset asserted mid-burst → all valid outputs drop to 0 immediately.
